// File: rtl/mux4_rr_sampler.sv
// Round-robin sampler that sits in front of a 4:1 bus mux and hands out one captured word at a time.
// Latency: sel is valid one edge after a request is seen in IDLE; the word and grant appear one edge later.
// Backpressure: the held word waits until out_ready is seen; requests are re-arbitrated only after accept.
module mux4_rr_sampler #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  output logic [1:0]       sel,
  input  logic [WIDTH-1:0] mux_q,
  output logic [3:0]       grant,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_chan,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SAMPLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Channel served by the most recent accepted transfer; the search starts just after it.
  logic [1:0] last;

  logic [1:0] win;
  logic       win_vld;
  logic       accept;

  logic [1:0]       sel_nxt;
  logic [3:0]       grant_nxt;
  logic [WIDTH-1:0] out_data_nxt;
  logic [1:0]       out_chan_nxt;
  logic             out_valid_nxt;
  logic [1:0]       last_nxt;

  assign accept = (state == HOLD) && out_valid && out_ready;

  // Round-robin pick: scan last+4 down to last+1 so the nearest requester after last wins.
  always_comb begin
    logic [1:0] cand;
    win     = last;
    win_vld = 1'b0;
    cand    = last;
    for (int k = 4; k >= 1; k--) begin
      cand = last + k[1:0];
      if (req[cand]) begin
        win     = cand;
        win_vld = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> SAMPLE on any request, SAMPLE always -> HOLD, HOLD -> IDLE on accept.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = SAMPLE;
      SAMPLE:  state_nxt = HOLD;
      HOLD:    if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; every output leaves the block through a flop.
  always_comb begin
    sel_nxt       = sel;
    grant_nxt     = 4'b0000;
    out_data_nxt  = out_data;
    out_chan_nxt  = out_chan;
    out_valid_nxt = out_valid;
    last_nxt      = last;
    case (state)
      IDLE: begin
        if (win_vld) sel_nxt = win;
      end
      SAMPLE: begin
        // Commit the capture regardless of whether req[sel] is still high.
        out_data_nxt  = mux_q;
        out_chan_nxt  = sel;
        out_valid_nxt = 1'b1;
        grant_nxt     = 4'b0001 << sel;
      end
      HOLD: begin
        if (accept) begin
          out_valid_nxt = 1'b0;
          last_nxt      = out_chan;
        end
      end
      default: begin
        out_valid_nxt = 1'b0;
      end
    endcase
  end

  // Output and bookkeeping registers; reset drops any in-flight word and restarts priority at ch0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= 2'd0;
      grant     <= 4'b0000;
      out_data  <= '0;
      out_chan  <= 2'd0;
      out_valid <= 1'b0;
      last      <= 2'd3;
    end else begin
      sel       <= sel_nxt;
      grant     <= grant_nxt;
      out_data  <= out_data_nxt;
      out_chan  <= out_chan_nxt;
      out_valid <= out_valid_nxt;
      last      <= last_nxt;
    end
  end

endmodule
